sprite_index_gen: RTL and testbench
===================================

# sprite_index_gen

Per-pixel sprite renderer that produces the 4-bit palette indices consumed by the sprite palette lookup. It compares the current VGA beam position against up to five sprite bounding boxes, fetches the winning sprite's texel from a synchronous sprite ROM, and emits a palette index, a hit flag, and a sprite ID. A fixed pipeline keeps these outputs aligned with the beam. The block also shadows sprite positions per frame and accumulates per-sprite bounding-box collision flags for game logic.

## Interface
Parameters:
- NUM_SPRITES, 5, number of sprites; sprite ID width is 3 bits.
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels (power of two).
- TRANSPARENT_IDX, 1, palette index treated as transparent (magenta key).

Ports:
- Clk  in  1  system clock (pixel-rate enable supplied via pix_valid).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse during vertical blanking.
- sprite_x  in  NUM_SPRITES×10  live sprite X (left edge), unsigned.
- sprite_y  in  NUM_SPRITES×10  live sprite Y (top edge), unsigned.
- sprite_en  in  NUM_SPRITES  live sprite enable.
- drawX, drawY  in  10 each  current beam position.
- pix_valid  in  1  beam in active region this cycle.
- rom_addr  out  13  {id[2:0], row[4:0], col[4:0]} to the sprite ROM.
- rom_data  in  4  texel from the ROM, valid one cycle after rom_addr is registered.
- index  out  4  palette index.
- hit  out  1  index is an opaque sprite texel.
- hit_id  out  3  sprite that produced the hit.
- out_valid  out  1  index/hit/hit_id correspond to a pix_valid pixel.
- coll_flags  out  NUM_SPRITES  per-sprite box collision from the previous frame.

## Operation
- Shadow registers:
  - On frame_start, sprite_x/sprite_y/sprite_en are copied into shadow registers.
  - All hit tests use only the shadow registers, so a sprite never tears mid-frame.
- Box test, sprite i:
  - Hit requires shadow en[i].
  - X: sx ≤ drawX < sx+SPR_W.
  - Y: sy ≤ drawY < sy+SPR_H.
  - Sums are computed at 11 bits, so sprites near 1023 clip instead of wrapping.
- Priority:
  - The lowest-numbered hitting sprite wins (sprite 0 on top).
  - Only the winner's texel is fetched. A transparent winner does not reveal lower sprites.
- Address: col = drawX−sx[4:0], row = drawY−sy[4:0].
- Output:
  - If the winner exists and rom_data ≠ TRANSPARENT_IDX: index=rom_data, hit=1, hit_id=winner.
  - Otherwise: index=0, hit=0, hit_id=0.
- Collision accumulator:
  - On any pix_valid pixel where two or more shadow boxes hit, all hitting sprites' bits are OR-set.
  - On frame_start, coll_flags ← accumulator and the accumulator ← 0.
- Pipeline stages:
  - S1: hit vector, priority encode, register rom_addr/id/valid.
  - S2: ROM access.
  - S3: register outputs.
- No stalls and no backpressure.

## Timing
- Latency is fixed at 3 cycles: pix_valid sampled at edge t gives out_valid high in the cycle after edge t+3.
- rom_addr is registered at edge t+1. rom_data is sampled at edge t+3.
- Throughput is one pixel per cycle. Back-to-back pix_valid is supported.
- frame_start coincident with pix_valid: that pixel uses the pre-update shadow values.
- frame_start coincident with an S1 accumulator update: the update is discarded. The new frame starts clear.
- Reset values:
  - All shadow registers 0 (all sprites disabled).
  - Accumulator 0, coll_flags 0.
  - Pipeline valids 0, index 0, hit 0, hit_id 0, out_valid 0, rom_addr 0.
- Reset asserted mid-pipeline flushes all in-flight pixels. No output is valid until 3 cycles after the first post-reset pix_valid.
- When pix_valid=0, the held rom_addr value is a don't-care. out_valid follows pix_valid delayed by 3.

## Structure
- Package sprite_pkg holds:
  - NUM_SPRITES, SPR_W, SPR_H, TRANSPARENT_IDX, ID_W=3.
  - typedef sprite_pos_t (10-bit x, 10-bit y, en).
  - typedef rom_addr_t.
- Sub-module sprite_hit_prio: the combinational box test plus priority encoder. It returns winner, found, and the multi-hit vector.
- The top level owns the shadow registers, pipeline registers, and collision accumulator.

## Test plan
- Sprite 0 at (100,50), enabled, ROM texel 7 at row 0 col 0; pixel (100,50) → 3 cycles later index=7, hit=1, hit_id=0, rom_addr=0x0000.
- Sprites 0 and 2 both covering (200,200); sprite 0 texel = TRANSPARENT_IDX → hit=0, index=0. After the next frame_start, coll_flags=5'b00101.
- Live sprite_x changed mid-frame from 10 to 300 → hits stay at X 10–41 until frame_start, then move to 300–331.
- Sprite at x=1000, pixel drawX=1023 → hit with col=23. drawX=5 → no hit (no wraparound).
- Continuous pix_valid stream, Reset_n pulsed low at an arbitrary cycle → all outputs 0 immediately. out_valid resumes exactly 3 cycles after the first post-reset pix_valid.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite index generator.
//   NUM_SPRITES / SPR_W / SPR_H  : sprite count and box size (power of two)
//   TRANSPARENT_IDX              : colour-key palette index (magenta)
//   ID_W / COL_W / ROW_W         : field widths of a sprite ROM address
//   sprite_pos_t                 : one sprite's position and enable
//   rom_addr_t                   : {id, row, col} sprite ROM address
package sprite_pkg;

  localparam int NUM_SPRITES = 5;
  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd1;
  localparam int ID_W        = 3;
  localparam int COL_W       = $clog2(SPR_W);
  localparam int ROW_W       = $clog2(SPR_H);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_pos_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } rom_addr_t;

  // Exclusive end of a box edge, widened to 11 bits so a sprite placed
  // near 1023 clips at the screen edge rather than wrapping to 0.
  function automatic logic [10:0] box_end(input logic [9:0] origin, input int size);
    return {1'b0, origin} + 11'(size);
  endfunction

endpackage

// File: rtl/sprite_hit_prio.sv
// Combinational bounding-box test and priority encoder.
//   spr_i      : per-sprite position/enable (frame-stable shadow copy)
//   draw_x_i/y : current beam position
//   hit_vec_o  : one bit per sprite whose box contains the beam
//   multi_o    : hit_vec_o when two or more sprites hit, otherwise 0
//   winner_o   : lowest-numbered hitting sprite (0 when none)
//   found_o    : at least one sprite hit
module sprite_hit_prio import sprite_pkg::*; #(
  parameter int NUM_SPR = 5,
  parameter int BOX_W   = 32,
  parameter int BOX_H   = 32
) (
  input  sprite_pos_t         spr_i [NUM_SPR],
  input  logic [9:0]          draw_x_i,
  input  logic [9:0]          draw_y_i,
  output logic [NUM_SPR-1:0]  hit_vec_o,
  output logic [NUM_SPR-1:0]  multi_o,
  output logic [ID_W-1:0]     winner_o,
  output logic                found_o
);

  logic [NUM_SPR-1:0] hit_less_one;

  always_comb begin
    hit_vec_o = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      hit_vec_o[i] = spr_i[i].en
                  && ({1'b0, draw_x_i} >= {1'b0, spr_i[i].x})
                  && ({1'b0, draw_x_i} <  box_end(spr_i[i].x, BOX_W))
                  && ({1'b0, draw_y_i} >= {1'b0, spr_i[i].y})
                  && ({1'b0, draw_y_i} <  box_end(spr_i[i].y, BOX_H));
    end
  end

  // Scan from the top index down so the lowest hitting index is left last.
  always_comb begin
    winner_o = '0;
    found_o  = |hit_vec_o;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_vec_o[i]) winner_o = ID_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign hit_less_one = hit_vec_o & (hit_vec_o - NUM_SPR'(1));
  assign multi_o      = (hit_less_one != '0) ? hit_vec_o : '0;

endmodule

// File: rtl/sprite_index_gen.sv
// Per-pixel sprite renderer producing 4-bit palette indices.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   frame_start           : vblank pulse; latches shadow regs and coll_flags
//   sprite_x/y/en         : live sprite positions and enables
//   drawX, drawY          : beam position, qualified by pix_valid
//   rom_addr / rom_data   : synchronous sprite ROM, {id,row,col} address
//   index/hit/hit_id      : rendered texel, 3 cycles after pix_valid
//   out_valid             : pix_valid delayed by 3
//   coll_flags            : per-sprite box collisions of the previous frame
module sprite_index_gen #(
  parameter int         NUM_SPRITES     = sprite_pkg::NUM_SPRITES,
  parameter int         SPR_W           = sprite_pkg::SPR_W,
  parameter int         SPR_H           = sprite_pkg::SPR_H,
  parameter logic [3:0] TRANSPARENT_IDX = sprite_pkg::TRANSPARENT_IDX
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic [NUM_SPRITES*10-1:0] sprite_x,
  input  logic [NUM_SPRITES*10-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [9:0]                drawX,
  input  logic [9:0]                drawY,
  input  logic                      pix_valid,
  output logic [12:0]               rom_addr,
  input  logic [3:0]                rom_data,
  output logic [3:0]                index,
  output logic                      hit,
  output logic [2:0]                hit_id,
  output logic                      out_valid,
  output logic [NUM_SPRITES-1:0]    coll_flags
);

  import sprite_pkg::*;

  sprite_pos_t live      [NUM_SPRITES];
  sprite_pos_t shadow_q  [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] hit_vec;
  logic [NUM_SPRITES-1:0] multi_vec;
  logic [ID_W-1:0]        winner;
  logic                   found;
  logic [9:0]             sel_x;
  logic [9:0]             sel_y;

  logic [NUM_SPRITES-1:0] acc_q;
  logic [NUM_SPRITES-1:0] coll_q;

  logic                   vld_p0_q, found_p0_q;
  logic [ID_W-1:0]        id_p0_q;
  logic [COL_W-1:0]       col_p0_q;
  logic [ROW_W-1:0]       row_p0_q;

  logic                   vld_p1_q, found_p1_q;
  logic [ID_W-1:0]        id_p1_q;
  rom_addr_t              rom_addr_q;

  logic                   vld_p2_q, found_p2_q;
  logic [ID_W-1:0]        id_p2_q;

  logic [3:0]             index_d, index_q;
  logic                   hit_d, hit_q;
  logic [ID_W-1:0]        hit_id_d, hit_id_q;
  logic                   out_valid_q;

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      live[i].x  = sprite_x[i*10 +: 10];
      live[i].y  = sprite_y[i*10 +: 10];
      live[i].en = sprite_en[i];
    end
  end

  sprite_hit_prio #(
    .NUM_SPR (NUM_SPRITES),
    .BOX_W   (SPR_W),
    .BOX_H   (SPR_H)
  ) u_hit_prio (
    .spr_i     (shadow_q),
    .draw_x_i  (drawX),
    .draw_y_i  (drawY),
    .hit_vec_o (hit_vec),
    .multi_o   (multi_vec),
    .winner_o  (winner),
    .found_o   (found)
  );

  // Origin of the winning sprite; the winner is always in range when found.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (winner == ID_W'(i)) begin
        sel_x = shadow_q[i].x;
        sel_y = shadow_q[i].y;
      end
    end
  end

  // Texel colour key: a transparent winner still hides lower sprites.
  always_comb begin
    index_d  = '0;
    hit_d    = 1'b0;
    hit_id_d = '0;
    if (vld_p2_q && found_p2_q && (rom_data != TRANSPARENT_IDX)) begin
      index_d  = rom_data;
      hit_d    = 1'b1;
      hit_id_d = id_p2_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= '0;
      acc_q       <= '0;
      coll_q      <= '0;
      vld_p0_q    <= 1'b0;
      found_p0_q  <= 1'b0;
      id_p0_q     <= '0;
      col_p0_q    <= '0;
      row_p0_q    <= '0;
      vld_p1_q    <= 1'b0;
      found_p1_q  <= 1'b0;
      id_p1_q     <= '0;
      rom_addr_q  <= '0;
      vld_p2_q    <= 1'b0;
      found_p2_q  <= 1'b0;
      id_p2_q     <= '0;
      index_q     <= '0;
      hit_q       <= 1'b0;
      hit_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Frame boundary: the box test above already used the old shadow copy
      // this cycle, and any collision seen this cycle is dropped so the new
      // frame starts clear.
      if (frame_start) begin
        for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= live[i];
        coll_q <= acc_q;
        acc_q  <= '0;
      end else if (pix_valid) begin
        acc_q <= acc_q | multi_vec;
      end

      // S1a: box test and priority encode captured with the texel offset
      vld_p0_q   <= pix_valid;
      found_p0_q <= pix_valid & found;
      id_p0_q    <= winner;
      col_p0_q   <= drawX[COL_W-1:0] - sel_x[COL_W-1:0];
      row_p0_q   <= drawY[ROW_W-1:0] - sel_y[ROW_W-1:0];

      // S1b: ROM address registered; held while no pixel is in flight
      vld_p1_q   <= vld_p0_q;
      found_p1_q <= found_p0_q;
      id_p1_q    <= id_p0_q;
      if (vld_p0_q) begin
        rom_addr_q.id  <= id_p0_q;
        rom_addr_q.row <= row_p0_q;
        rom_addr_q.col <= col_p0_q;
      end

      // S2: ROM access in flight
      vld_p2_q   <= vld_p1_q;
      found_p2_q <= found_p1_q;
      id_p2_q    <= id_p1_q;

      // S3: registered outputs
      index_q     <= index_d;
      hit_q       <= hit_d;
      hit_id_q    <= hit_id_d;
      out_valid_q <= vld_p2_q;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign index      = index_q;
  assign hit        = hit_q;
  assign hit_id     = hit_id_q;
  assign out_valid  = out_valid_q;
  assign coll_flags = coll_q;

endmodule

// File: tb/tb_sprite_index_gen.sv
// Directed-vector bench for sprite_index_gen with a behavioural sync ROM.
module tb_sprite_index_gen;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [49:0] sprite_x;
  logic [49:0] sprite_y;
  logic [4:0]  sprite_en;
  logic [9:0]  drawX, drawY;
  logic        pix_valid;
  logic [12:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  index;
  logic        hit;
  logic [2:0]  hit_id;
  logic        out_valid;
  logic [4:0]  coll_flags;

  int nvec = 0;
  int nmis = 0;

  always #5 Clk = ~Clk;

  sprite_index_gen dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_start(frame_start),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_en  (sprite_en),
    .drawX      (drawX),
    .drawY      (drawY),
    .pix_valid  (pix_valid),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .index      (index),
    .hit        (hit),
    .hit_id     (hit_id),
    .out_valid  (out_valid),
    .coll_flags (coll_flags)
  );

  // ROM contents: id0 (0,0)=7, id0 (row10,col10)=1 (transparent),
  // other id2 texels 0xC, everything else 0xA.
  function automatic logic [3:0] rom_f(input logic [12:0] a);
    if (a == 13'd0)                     return 4'd7;
    if (a == {3'd0, 5'd10, 5'd10})      return 4'd1;
    if (a[12:10] == 3'd2)               return 4'hC;
    return 4'hA;
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_spr(input int i, input int x, input int y, input bit en);
    sprite_x[i*10 +: 10] = 10'(x);
    sprite_y[i*10 +: 10] = 10'(y);
    sprite_en[i]         = en;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    @(posedge Clk); #1;
    frame_start = 1'b0;
  endtask

  // One isolated pixel; checks rom_addr after S1 and outputs after S3.
  task automatic pix(input string tag, input int x, input int y,
                     input bit chk_addr, input logic [12:0] exp_addr,
                     input logic [3:0] exp_idx, input bit exp_hit,
                     input logic [2:0] exp_id);
    drawX = 10'(x); drawY = 10'(y); pix_valid = 1'b1;
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    @(posedge Clk); #1;
    if (chk_addr) chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    @(posedge Clk); #1;
    chk({tag, ".early"}, 32'(out_valid), 32'd0);
    @(posedge Clk); #1;
    chk({tag, ".ov"},  32'(out_valid), 32'd1);
    chk({tag, ".idx"}, 32'(index),     32'(exp_idx));
    chk({tag, ".hit"}, 32'(hit),       32'(exp_hit));
    chk({tag, ".id"},  32'(hit_id),    32'(exp_id));
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    drawX = '0; drawY = '0; sprite_x = '0; sprite_y = '0; sprite_en = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.idx",  32'(index),      32'd0);
    chk("rst.hit",  32'(hit),        32'd0);
    chk("rst.id",   32'(hit_id),     32'd0);
    chk("rst.ov",   32'(out_valid),  32'd0);
    chk("rst.addr", 32'(rom_addr),   32'd0);
    chk("rst.coll", 32'(coll_flags), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    // Basic texel fetch
    set_spr(0, 100, 50, 1'b1);
    do_frame();
    pix("p0",   100, 50, 1'b1, 13'h0000, 4'd7, 1'b1, 3'd0);
    pix("p0br", 131, 81, 1'b1, 13'h03FF, 4'hA, 1'b1, 3'd0);
    pix("p0xr", 132, 50, 1'b0, 13'h0,    4'd0, 1'b0, 3'd0);
    pix("p0xl",  99, 50, 1'b0, 13'h0,    4'd0, 1'b0, 3'd0);

    // Overlap: transparent sprite 0 hides sprite 2; collisions accumulate
    set_spr(0, 190, 190, 1'b1);
    set_spr(2, 200, 200, 1'b1);
    do_frame();
    chk("coll.none", 32'(coll_flags), 32'd0);
    pix("ovl", 200, 200, 1'b1, 13'h014A, 4'd0, 1'b0, 3'd0);
    pix("s0",  215, 195, 1'b0, 13'h0,    4'hA, 1'b1, 3'd0);
    pix("s2",  225, 225, 1'b1, 13'h0B39, 4'hC, 1'b1, 3'd2);
    do_frame();
    chk("coll.set", 32'(coll_flags), 32'b00101);
    do_frame();
    chk("coll.clr", 32'(coll_flags), 32'd0);

    // Live position change only takes effect at frame_start
    set_spr(2, 0, 0, 1'b0);
    set_spr(0, 10, 0, 1'b1);
    do_frame();
    pix("t.old0", 10, 0, 1'b1, 13'h0000, 4'd7, 1'b1, 3'd0);
    set_spr(0, 300, 0, 1'b1);
    pix("t.old1",  41, 5, 1'b0, 13'h0, 4'hA, 1'b1, 3'd0);
    pix("t.newx", 300, 5, 1'b0, 13'h0, 4'd0, 1'b0, 3'd0);
    do_frame();
    pix("t.new",  300, 5, 1'b1, 13'h00A0, 4'hA, 1'b1, 3'd0);
    pix("t.oldx",  10, 0, 1'b0, 13'h0,    4'd0, 1'b0, 3'd0);

    // Right-edge clipping, no wraparound
    set_spr(0, 1000, 0, 1'b1);
    do_frame();
    pix("clip",  1023, 3, 1'b1, 13'h0077, 4'hA, 1'b1, 3'd0);
    pix("nowrap",   5, 3, 1'b0, 13'h0,    4'd0, 1'b0, 3'd0);

    // Continuous stream, then reset mid-pipeline
    drawX = 10'd1010; drawY = 10'd3; pix_valid = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    chk("st.ov",   32'(out_valid), 32'd1);
    chk("st.idx",  32'(index),     32'hA);
    chk("st.addr", 32'(rom_addr),  32'h006A);
    #3 Reset_n = 1'b0;
    #1;
    chk("mr.ov",   32'(out_valid), 32'd0);
    chk("mr.idx",  32'(index),     32'd0);
    chk("mr.hit",  32'(hit),       32'd0);
    chk("mr.addr", 32'(rom_addr),  32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("rr.ov1", 32'(out_valid), 32'd0);
    @(posedge Clk); #1;
    chk("rr.ov2", 32'(out_valid), 32'd0);
    @(posedge Clk); #1;
    chk("rr.ov3", 32'(out_valid), 32'd0);
    @(posedge Clk); #1;
    chk("rr.ov4", 32'(out_valid), 32'd1);
    chk("rr.hit", 32'(hit),       32'd0);
    pix_valid = 1'b0;
    @(posedge Clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
